// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: one 1-bit alu_top slice is stepped LSB first across WIDTH clocks.
// Optional abort input is compiled in with SERIAL_ALU_ABORT_EN.

module alu_top (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       binv_i,
  input  logic       cin_i,
  input  logic [1:0] op_i,
  output logic       res_o,
  output logic       cout_o
);
  logic bb;

  always_comb begin
    bb     = b_i ^ binv_i;
    cout_o = (a_i & bb) | (a_i & cin_i) | (bb & cin_i);
    case (op_i)
      2'd0:    res_o = a_i & bb;
      2'd1:    res_o = a_i | bb;
      2'd2:    res_o = a_i ^ bb ^ cin_i;
      default: res_o = bb;
    endcase
  end
endmodule

module serial_alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
`ifdef SERIAL_ALU_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             slt_q, slt_d, fovf_q, fovf_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;

  logic             abort;
  logic             binv, arith, is_slt, last;
  logic [1:0]       slice_op;
  logic             s_res, s_cout, ovf_bit;
  logic [WIDTH-1:0] sh_next;

`ifdef SERIAL_ALU_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    is_slt   = (op_q == OP_SLT);
    binv     = (op_q == OP_SUB) || is_slt;
    arith    = (op_q == 3'd2) || binv;
    slice_op = (op_q == 3'd0) ? 2'd0 :
               (op_q == 3'd1) ? 2'd1 :
               arith          ? 2'd2 : 2'd3;
    last     = (cnt_q == CW'(WIDTH-1));
  end

  alu_top u_slice (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .binv_i (binv),
    .cin_i  (carry_q),
    .op_i   (slice_op),
    .res_o  (s_res),
    .cout_o (s_cout)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    slt_d    = slt_q;
    fovf_d   = fovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    sh_next  = {s_res, sh_q[WIDTH-1:1]};
    // carry into the MSB is still in carry_q while the last bit is computed
    ovf_bit  = carry_q ^ s_cout;

    case (state_q)
      IDLE: if (start_i) begin
        state_d = RUN;
        op_d    = op_i;
        a_d     = src1_i;
        b_d     = src2_i;
        cnt_d   = '0;
        carry_d = (op_i == OP_SUB) || (op_i == OP_SLT);
        busy_d  = 1'b1;
      end
      RUN: if (abort) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end else begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sh_d    = sh_next;
        carry_d = s_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          if (is_slt) begin
            state_d = FIX;
            slt_d   = s_res ^ ovf_bit;
            fovf_d  = ovf_bit;
          end else begin
            state_d  = DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = sh_next;
            zero_d   = (sh_next == '0);
            cout_d   = arith & s_cout;
            ovf_d    = arith & ovf_bit;
          end
        end
      end
      FIX: if (abort) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end else begin
        state_d  = DONE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = {{(WIDTH-1){1'b0}}, slt_q};
        zero_d   = ~slt_q;
        cout_d   = carry_q;
        ovf_d    = fovf_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      slt_q    <= 1'b0;
      fovf_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      slt_q    <= slt_d;
      fovf_q   <= fovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl at WIDTH=32; abort scenario only when SERIAL_ALU_ABORT_EN is set.
module tb_serial_alu_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] src1_i = '0, src2_i = '0;
  logic        abort_i = 1'b0;
  logic        busy_o, done_o, zero_o, cout_o, overflow_o;
  logic [31:0] result_o;
  int          errs = 0, checks = 0;

  always #5 clk_i = ~clk_i;

  serial_alu_ctrl #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i),
`ifdef SERIAL_ALU_ABORT_EN
    .abort_i(abort_i),
`endif
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .zero_o(zero_o),
    .cout_o(cout_o), .overflow_o(overflow_o)
  );

  // Issues one request from IDLE and returns cycles from the accept edge to done_o (-1 on timeout).
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk_i); #1;
      if (done_o) begin lat = n; break; end
    end
  endtask

  task automatic settle();
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", done_o); end
    checks++; if (result_o !== 32'h0) begin errs++; $display("FAIL reset_result got=%h exp=0", result_o); end
    checks++; if ({zero_o, cout_o, overflow_o} !== 3'b100) begin errs++;
      $display("FAIL reset_flags got=%b exp=100", {zero_o, cout_o, overflow_o}); end
    rst_n = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_add();
    int lat;
    do_op(3'd2, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    checks++; if (lat !== 32) begin errs++; $display("FAIL add_latency got=%0d exp=32", lat); end
    checks++; if (result_o !== 32'h8000_0000) begin errs++; $display("FAIL add_result got=%h exp=80000000", result_o); end
    checks++; if ({zero_o, cout_o, overflow_o} !== 3'b001) begin errs++;
      $display("FAIL add_flags zco got=%b exp=001", {zero_o, cout_o, overflow_o}); end
    settle();
    checks++; if (done_o !== 1'b0) begin errs++; $display("FAIL add_done_pulse got=%b exp=0", done_o); end
    do_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    settle();
    checks++; if ({result_o, zero_o, cout_o, overflow_o} !== {32'h0, 3'b110}) begin errs++;
      $display("FAIL add_wrap got=%h/%b exp=00000000/110", result_o, {zero_o, cout_o, overflow_o}); end
  endtask

  task automatic test_sub();
    int lat;
    do_op(3'd3, 32'd5, 32'd5, lat);
    settle();
    checks++; if (result_o !== 32'h0) begin errs++; $display("FAIL sub_result got=%h exp=0", result_o); end
    checks++; if ({zero_o, cout_o, overflow_o} !== 3'b110) begin errs++;
      $display("FAIL sub_flags zco got=%b exp=110", {zero_o, cout_o, overflow_o}); end
    do_op(3'd3, 32'd3, 32'd10, lat);
    settle();
    checks++; if (result_o !== 32'hFFFF_FFF9 || cout_o !== 1'b0) begin errs++;
      $display("FAIL sub_neg got=%h c=%b exp=fffffff9 c=0", result_o, cout_o); end
  endtask

  task automatic test_slt();
    int lat;
    do_op(3'd4, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    checks++; if (lat !== 33) begin errs++; $display("FAIL slt_latency got=%0d exp=33", lat); end
    checks++; if ({result_o, cout_o, overflow_o} !== {32'h1, 2'b10}) begin errs++;
      $display("FAIL slt_neg got=%h/%b exp=00000001/10", result_o, {cout_o, overflow_o}); end
    settle();
    do_op(3'd4, 32'h8000_0000, 32'h7FFF_FFFF, lat);
    checks++; if ({result_o, overflow_o} !== {32'h1, 1'b1}) begin errs++;
      $display("FAIL slt_ovf got=%h v=%b exp=00000001 v=1", result_o, overflow_o); end
    settle();
    do_op(3'd4, 32'h0000_0001, 32'hFFFF_FFFF, lat);
    checks++; if ({result_o, zero_o} !== {32'h0, 1'b1}) begin errs++;
      $display("FAIL slt_false got=%h z=%b exp=00000000 z=1", result_o, zero_o); end
    settle();
  endtask

  task automatic test_logic();
    int lat;
    do_op(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    checks++; if (result_o !== 32'hF000_F000) begin errs++; $display("FAIL and_result got=%h exp=f000f000", result_o); end
    settle();
    do_op(3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    checks++; if (result_o !== 32'hFFF0_FFF0) begin errs++; $display("FAIL or_result got=%h exp=fff0fff0", result_o); end
    settle();
    do_op(3'd5, 32'hFFFF_FFFF, 32'hFF00_FF00, lat);
    checks++; if ({result_o, cout_o, overflow_o} !== {32'hFF00_FF00, 2'b00}) begin errs++;
      $display("FAIL pass_result got=%h/%b exp=ff00ff00/00", result_o, {cout_o, overflow_o}); end
    settle();
    do_op(3'd7, 32'h1234_5678, 32'h0BAD_F00D, lat);
    checks++; if (result_o !== 32'h0BAD_F00D) begin errs++; $display("FAIL pass7_result got=%h exp=0badf00d", result_o); end
    settle();
  endtask

  task automatic test_back_to_back();
    int first_n = -1, second_n = -1, ndone = 0;
    logic [31:0] r1 = '0, r2 = '0;
    logic busy33 = 1'b1;
    @(negedge clk_i);
    start_i = 1'b1; op_i = 3'd2; src1_i = 32'd1; src2_i = 32'd2;
    @(posedge clk_i); #1;
    src1_i = 32'd10; src2_i = 32'd20;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk_i); #1;
      if (n == 33) busy33 = busy_o;
      if (n == 34) start_i = 1'b0;
      if (done_o) begin
        ndone++;
        if (first_n < 0) begin first_n = n; r1 = result_o; end
        else if (second_n < 0) begin second_n = n; r2 = result_o; end
      end
    end
    checks++; if (first_n !== 32 || r1 !== 32'd3) begin errs++;
      $display("FAIL b2b_first got=%0d/%0d exp=32/3", first_n, r1); end
    checks++; if (busy33 !== 1'b0) begin errs++; $display("FAIL b2b_idle_gap got=%b exp=0", busy33); end
    checks++; if (second_n !== 66 || r2 !== 32'd30) begin errs++;
      $display("FAIL b2b_second got=%0d/%0d exp=66/30", second_n, r2); end
    checks++; if (ndone !== 2) begin errs++; $display("FAIL b2b_done_count got=%0d exp=2", ndone); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    @(negedge clk_i);
    start_i = 1'b1; op_i = 3'd2; src1_i = 32'h1111_1111; src2_i = 32'h2222_2222;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({busy_o, done_o, result_o, zero_o, cout_o, overflow_o} !== {2'b00, 32'h0, 3'b100}) begin errs++;
      $display("FAIL rst_mid got=%b%b %h %b exp=00 00000000 100", busy_o, done_o, result_o,
               {zero_o, cout_o, overflow_o}); end
    @(negedge clk_i);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk_i); #1;
      if (done_o) ndone++;
    end
    checks++; if (ndone !== 0) begin errs++; $display("FAIL rst_mid_no_done got=%0d exp=0", ndone); end
  endtask

`ifdef SERIAL_ALU_ABORT_EN
  task automatic test_abort();
    int lat, ndone = 0;
    do_op(3'd2, 32'd1, 32'd2, lat);
    settle();
    @(negedge clk_i);
    start_i = 1'b1; op_i = 3'd2; src1_i = 32'd5; src2_i = 32'd6;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    checks++; if ({busy_o, done_o, result_o} !== {2'b00, 32'd3}) begin errs++;
      $display("FAIL abort_state got=%b%b %h exp=00 00000003", busy_o, done_o, result_o); end
    for (int n = 0; n < 40; n++) begin
      @(posedge clk_i); #1;
      if (done_o) ndone++;
    end
    checks++; if (ndone !== 0) begin errs++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_ALU_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
